// File: rtl/fft8_serial_if.sv
// Streaming ports of the 8-point FFT engine: a sample input stream and a
// spectrum-bin output stream. The engine side uses the slave modport.
interface fft8_serial_if #(
   parameter int DATA_W = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [2*DATA_W-1:0] in_data;
   logic                out_valid;
   logic                out_ready;
   logic [2*DATA_W-1:0] out_data;
   logic [2:0]          out_index;
   logic                out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_index, out_last
   );
endinterface

// File: rtl/fft8_serial.sv
// Serial 8-point radix-2 DIT forward FFT: bit-reversed load, 12 in-place
// butterflies through one shared unit, natural-order unload. FFT_SCALE_EN adds >>>1 per stage.

module fft8_bfly #(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16
) (
   input  logic signed [DATA_W-1:0] a_re,
   input  logic signed [DATA_W-1:0] a_im,
   input  logic signed [DATA_W-1:0] b_re,
   input  logic signed [DATA_W-1:0] b_im,
   input  logic signed [DATA_W-1:0] w_re,
   input  logic signed [DATA_W-1:0] w_im,
   output logic signed [DATA_W-1:0] y0_re,
   output logic signed [DATA_W-1:0] y0_im,
   output logic signed [DATA_W-1:0] y1_re,
   output logic signed [DATA_W-1:0] y1_im
);
   logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [2*DATA_W-1:0] t_re_full, t_im_full;
   logic signed [DATA_W-1:0]   t_re, t_im;
   logic signed [DATA_W-1:0]   s_re, s_im, d_re, d_im;

   always_comb begin
      p_rr = (2*DATA_W)'(b_re) * (2*DATA_W)'(w_re);
      p_ii = (2*DATA_W)'(b_im) * (2*DATA_W)'(w_im);
      p_ri = (2*DATA_W)'(b_re) * (2*DATA_W)'(w_im);
      p_ir = (2*DATA_W)'(b_im) * (2*DATA_W)'(w_re);
      t_re_full = p_rr - p_ii;
      t_im_full = p_ri + p_ir;
      // floor-truncate the full-precision sum back to Q format
      t_re = DATA_W'(t_re_full >>> FRAC_W);
      t_im = DATA_W'(t_im_full >>> FRAC_W);
      s_re = a_re + t_re;
      s_im = a_im + t_im;
      d_re = a_re - t_re;
      d_im = a_im - t_im;
`ifdef FFT_SCALE_EN
      y0_re = s_re >>> 1;
      y0_im = s_im >>> 1;
      y1_re = d_re >>> 1;
      y1_im = d_im >>> 1;
`else
      y0_re = s_re;
      y0_im = s_im;
      y1_re = d_re;
      y1_im = d_im;
`endif
   end
endmodule

module fft8_serial #(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16
) (
   input  logic          clock,
   input  logic          reset,
   fft8_serial_if.slave  io,
   output logic          busy
);
   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

   // W8^k = e^(-j*2*pi*k/8), Q16.16
   localparam logic signed [DATA_W-1:0] W0_RE = DATA_W'(32'sh00010000);
   localparam logic signed [DATA_W-1:0] W0_IM = DATA_W'(32'sh00000000);
   localparam logic signed [DATA_W-1:0] W1_RE = DATA_W'(32'sh0000B505);
   localparam logic signed [DATA_W-1:0] W1_IM = DATA_W'(32'shFFFF4AFB);
   localparam logic signed [DATA_W-1:0] W2_RE = DATA_W'(32'sh00000000);
   localparam logic signed [DATA_W-1:0] W2_IM = DATA_W'(32'shFFFF0000);
   localparam logic signed [DATA_W-1:0] W3_RE = DATA_W'(32'shFFFF4AFB);
   localparam logic signed [DATA_W-1:0] W3_IM = DATA_W'(32'shFFFF4AFB);

   state_t state_q, state_d;
   logic [2:0] cnt_q, idx_q;
   logic [1:0] stage_q, bfly_q;
   logic [7:0][2*DATA_W-1:0] mem;

   logic [2:0] wr_addr, top_idx, bot_idx;
   logic [1:0] tw_k;
   logic signed [DATA_W-1:0] w_re, w_im;
   logic signed [DATA_W-1:0] y0_re, y0_im, y1_re, y1_im;
   logic load_fire, unload_fire, last_bfly;

   assign wr_addr     = {cnt_q[0], cnt_q[1], cnt_q[2]};
   assign load_fire   = (state_q == S_LOAD) && io.in_valid;
   assign unload_fire = (state_q == S_UNLOAD) && io.out_ready;
   assign last_bfly   = (stage_q == 2'd2) && (bfly_q == 2'd3);

   // top = (b>>s)*2*span + (b & (span-1)), k = (b & (span-1)) << (2-s)
   always_comb begin
      top_idx = '0;
      tw_k    = '0;
      case (stage_q)
         2'd0: begin
            top_idx = {bfly_q, 1'b0};
            tw_k    = 2'd0;
         end
         2'd1: begin
            top_idx = {bfly_q[1], 1'b0, bfly_q[0]};
            tw_k    = {bfly_q[0], 1'b0};
         end
         default: begin
            top_idx = {1'b0, bfly_q};
            tw_k    = bfly_q;
         end
      endcase
      bot_idx = top_idx + (3'd1 << stage_q);
   end

   always_comb begin
      w_re = W0_RE;
      w_im = W0_IM;
      case (tw_k)
         2'd1:    begin w_re = W1_RE; w_im = W1_IM; end
         2'd2:    begin w_re = W2_RE; w_im = W2_IM; end
         2'd3:    begin w_re = W3_RE; w_im = W3_IM; end
         default: begin w_re = W0_RE; w_im = W0_IM; end
      endcase
   end

   fft8_bfly #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_bfly (
      .a_re  (mem[top_idx][2*DATA_W-1:DATA_W]),
      .a_im  (mem[top_idx][DATA_W-1:0]),
      .b_re  (mem[bot_idx][2*DATA_W-1:DATA_W]),
      .b_im  (mem[bot_idx][DATA_W-1:0]),
      .w_re  (w_re),
      .w_im  (w_im),
      .y0_re (y0_re),
      .y0_im (y0_im),
      .y1_re (y1_re),
      .y1_im (y1_im)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_LOAD;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      io.in_ready  = 1'b0;
      io.out_valid = 1'b0;
      busy         = 1'b0;
      case (state_q)
         S_LOAD: begin
            io.in_ready = 1'b1;
            if (load_fire && cnt_q == 3'd7) state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            busy = 1'b1;
            if (last_bfly) state_d = S_UNLOAD;
         end
         S_UNLOAD: begin
            busy         = 1'b1;
            io.out_valid = 1'b1;
            if (unload_fire && idx_q == 3'd7) state_d = S_LOAD;
         end
         default: state_d = S_LOAD;
      endcase
   end

   // idx_q wraps back to 0 on the final handshake, so it reads 0 outside UNLOAD
   assign io.out_data  = io.out_valid ? mem[idx_q] : '0;
   assign io.out_index = idx_q;
   assign io.out_last  = io.out_valid && (idx_q == 3'd7);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         stage_q <= '0;
         bfly_q  <= '0;
      end else begin
         if (load_fire)   cnt_q <= cnt_q + 3'd1;
         if (unload_fire) idx_q <= idx_q + 3'd1;
         if (state_q == S_COMPUTE) begin
            bfly_q <= bfly_q + 2'd1;
            if (bfly_q == 2'd3) stage_q <= last_bfly ? 2'd0 : stage_q + 2'd1;
         end
      end
   end

   // buffer is deliberately not reset; both butterfly outputs land on one edge
   always_ff @(posedge clock) begin
      if (load_fire) begin
         mem[wr_addr] <= io.in_data;
      end else if (state_q == S_COMPUTE) begin
         mem[top_idx] <= {y0_re, y0_im};
         mem[bot_idx] <= {y1_re, y1_im};
      end
   end
endmodule
